// File: rtl/cnn_result_argmax.sv
// Joins the five per-class CNN score streams into one vector and emits the argmax class.
// Optional feature macro CNN_RESULT_SCORE_EN: also drive the winning score on result_score_TDATA.
module cnn_result_argmax #(
   parameter int PIXEL_BIT_WIDTH = 12,
   parameter int COUNT_BITWIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_0_TDATA,
   input  logic                       cnn_output_0_TVALID,
   output logic                       cnn_output_0_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_1_TDATA,
   input  logic                       cnn_output_1_TVALID,
   output logic                       cnn_output_1_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_2_TDATA,
   input  logic                       cnn_output_2_TVALID,
   output logic                       cnn_output_2_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_3_TDATA,
   input  logic                       cnn_output_3_TVALID,
   output logic                       cnn_output_3_TREADY,
   input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_4_TDATA,
   input  logic                       cnn_output_4_TVALID,
   output logic                       cnn_output_4_TREADY,
   output logic [2:0]                 result_class_TDATA,
   output logic [PIXEL_BIT_WIDTH-1:0] result_score_TDATA,
   output logic                       result_TVALID,
   input  logic                       result_TREADY,
   output logic [COUNT_BITWIDTH-1:0]  result_count
);

   localparam int NUM_CH = 5;
   localparam logic [COUNT_BITWIDTH-1:0] COUNT_ONE = {{(COUNT_BITWIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      COMPARE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t state_r;
   state_t state_next_s;

   logic [NUM_CH-1:0]                 tvalid_s;
   logic [NUM_CH-1:0]                 tready_s;
   logic [NUM_CH-1:0]                 capture_s;
   logic [NUM_CH-1:0]                 flags_next_s;
   logic [NUM_CH-1:0]                 captured_r;
   logic                              all_captured_s;
   logic                              result_fire_s;
   logic                              last_compare_s;

   logic signed [PIXEL_BIT_WIDTH-1:0] tdata_s [NUM_CH];
   logic signed [PIXEL_BIT_WIDTH-1:0] hold_r  [NUM_CH];
   logic signed [PIXEL_BIT_WIDTH-1:0] best_r;
   logic signed [PIXEL_BIT_WIDTH-1:0] best0_s;
   logic signed [PIXEL_BIT_WIDTH-1:0] cand_s;
   logic signed [PIXEL_BIT_WIDTH-1:0] final_score_s;
   logic [2:0]                        best_idx_r;
   logic [2:0]                        idx_r;
   logic [2:0]                        final_idx_s;

   logic                              result_valid_r;
   logic [2:0]                        result_class_r;
   logic [PIXEL_BIT_WIDTH-1:0]        result_score_r;
   logic [COUNT_BITWIDTH-1:0]         result_count_r;

   assign tdata_s[0] = cnn_output_0_TDATA;
   assign tdata_s[1] = cnn_output_1_TDATA;
   assign tdata_s[2] = cnn_output_2_TDATA;
   assign tdata_s[3] = cnn_output_3_TDATA;
   assign tdata_s[4] = cnn_output_4_TDATA;

   assign tvalid_s = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                      cnn_output_1_TVALID, cnn_output_0_TVALID};

   assign cnn_output_0_TREADY = tready_s[0];
   assign cnn_output_1_TREADY = tready_s[1];
   assign cnn_output_2_TREADY = tready_s[2];
   assign cnn_output_3_TREADY = tready_s[3];
   assign cnn_output_4_TREADY = tready_s[4];

   assign result_class_TDATA = result_class_r;
   assign result_score_TDATA = result_score_r;
   assign result_TVALID      = result_valid_r;
   assign result_count       = result_count_r;

   // Input handshake decode: ready depends only on state and capture flags.
   always_comb begin
      tready_s = {NUM_CH{1'b0}};
      if (state_r == COLLECT) begin
         tready_s = ~captured_r;
      end else begin
         tready_s = {NUM_CH{1'b0}};
      end
   end

   assign capture_s      = tvalid_s & tready_s;
   assign flags_next_s   = captured_r | capture_s;
   assign all_captured_s = &flags_next_s;
   assign result_fire_s  = result_valid_r & result_TREADY;
   assign last_compare_s = (state_r == COMPARE) && (idx_r == 3'd4);

   // Candidate selection and one signed compare step; ties keep the lower index.
   always_comb begin
      cand_s        = hold_r[0];
      final_idx_s   = best_idx_r;
      final_score_s = best_r;
      best0_s       = hold_r[0];
      case (idx_r)
         3'd1:    cand_s = hold_r[1];
         3'd2:    cand_s = hold_r[2];
         3'd3:    cand_s = hold_r[3];
         3'd4:    cand_s = hold_r[4];
         default: cand_s = hold_r[0];
      endcase
      if (cand_s > best_r) begin
         final_idx_s   = idx_r;
         final_score_s = cand_s;
      end else begin
         final_idx_s   = best_idx_r;
         final_score_s = best_r;
      end
      // Score 0 may arrive on the very edge that completes the vector.
      if (capture_s[0]) begin
         best0_s = tdata_s[0];
      end else begin
         best0_s = hold_r[0];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= COLLECT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         COLLECT: begin
            if (all_captured_s) begin
               state_next_s = COMPARE;
            end else begin
               state_next_s = COLLECT;
            end
         end
         COMPARE: begin
            if (idx_r == 3'd4) begin
               state_next_s = HOLD;
            end else begin
               state_next_s = COMPARE;
            end
         end
         HOLD: begin
            if (result_fire_s) begin
               state_next_s = COLLECT;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: state_next_s = COLLECT;
      endcase
   end

   // Capture registers, flags and running argmax.
   always_ff @(posedge clk) begin
      if (reset) begin
         captured_r <= {NUM_CH{1'b0}};
         best_r     <= '0;
         best_idx_r <= 3'd0;
         idx_r      <= 3'd0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold_r[k] <= '0;
         end
      end else begin
         case (state_r)
            COLLECT: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (capture_s[k]) begin
                     hold_r[k] <= tdata_s[k];
                  end
               end
               captured_r <= flags_next_s;
               if (all_captured_s) begin
                  best_r     <= best0_s;
                  best_idx_r <= 3'd0;
                  idx_r      <= 3'd1;
               end
            end
            COMPARE: begin
               best_r     <= final_score_s;
               best_idx_r <= final_idx_s;
               idx_r      <= idx_r + 3'd1;
            end
            HOLD: begin
               if (result_fire_s) begin
                  captured_r <= {NUM_CH{1'b0}};
               end
            end
            default: begin
               captured_r <= {NUM_CH{1'b0}};
            end
         endcase
      end
   end

   // Result channel and delivered-result counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_valid_r <= 1'b0;
         result_class_r <= 3'd0;
         result_score_r <= '0;
         result_count_r <= '0;
      end else if (last_compare_s) begin
         result_valid_r <= 1'b1;
         result_class_r <= final_idx_s;
`ifdef CNN_RESULT_SCORE_EN
         result_score_r <= final_score_s;
`else
         result_score_r <= '0;
`endif
      end else if (result_fire_s) begin
         result_valid_r <= 1'b0;
         result_count_r <= result_count_r + COUNT_ONE;
      end
   end

endmodule

// File: tb/tb_cnn_result_argmax.sv
// Directed self-checking bench for cnn_result_argmax (COUNT_BITWIDTH = 4 so the wrap is reachable).
module tb_cnn_result_argmax;

   localparam int W  = 12;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  d [5];
   logic [4:0]    v;
   logic [4:0]    rdy;
   logic [2:0]    rclass;
   logic [W-1:0]  rscore;
   logic          rvalid;
   logic          rready;
   logic [CW-1:0] rcount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cnn_result_argmax #(.PIXEL_BIT_WIDTH(W), .COUNT_BITWIDTH(CW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .cnn_output_0_TDATA  (d[0]),
      .cnn_output_0_TVALID (v[0]),
      .cnn_output_0_TREADY (rdy[0]),
      .cnn_output_1_TDATA  (d[1]),
      .cnn_output_1_TVALID (v[1]),
      .cnn_output_1_TREADY (rdy[1]),
      .cnn_output_2_TDATA  (d[2]),
      .cnn_output_2_TVALID (v[2]),
      .cnn_output_2_TREADY (rdy[2]),
      .cnn_output_3_TDATA  (d[3]),
      .cnn_output_3_TVALID (v[3]),
      .cnn_output_3_TREADY (rdy[3]),
      .cnn_output_4_TDATA  (d[4]),
      .cnn_output_4_TVALID (v[4]),
      .cnn_output_4_TREADY (rdy[4]),
      .result_class_TDATA  (rclass),
      .result_score_TDATA  (rscore),
      .result_TVALID       (rvalid),
      .result_TREADY       (rready),
      .result_count        (rcount)
   );

   function automatic logic [W-1:0] exp_score(input int s);
`ifdef CNN_RESULT_SCORE_EN
      return W'(s);
`else
      return W'(0) & W'(s);
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] mask, input int s0, input int s1, input int s2,
                        input int s3, input int s4);
      v    = mask;
      d[0] = W'(s0);
      d[1] = W'(s1);
      d[2] = W'(s2);
      d[3] = W'(s3);
      d[4] = W'(s4);
   endtask

   // Counts edges after the completing capture until result_TVALID rises (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      rready = 1'b0;
      drive(5'b00000, 0, 0, 0, 0, 0);
      tick;
      tick;
      reset = 1'b0;
      checks++; if (rdy !== 5'b11111) begin errors++; $display("FAIL reset_tready got %b want 11111", rdy); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", rvalid); end
      checks++; if (rclass !== 3'd0) begin errors++; $display("FAIL reset_class got %0d want 0", rclass); end
      checks++; if (rscore !== 12'd0) begin errors++; $display("FAIL reset_score got %h want 000", rscore); end
      checks++; if (rcount !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rcount); end
   endtask

   task automatic test_simultaneous;
      int n;
      rready = 1'b1;
      drive(5'b11111, 10, -3, 200, 7, 199);
      tick;
      v = 5'b00000;
      checks++; if (rdy !== 5'b00000) begin errors++; $display("FAIL simul_compare_tready got %b want 00000", rdy); end
      wait_valid(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL simul_latency got %0d want 4", n); end
      checks++; if (rclass !== 3'd2) begin errors++; $display("FAIL simul_class got %0d want 2", rclass); end
      checks++; if (rscore !== exp_score(200)) begin errors++; $display("FAIL simul_score got %h want %h", rscore, exp_score(200)); end
      tick;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL simul_tvalid_drop got %b want 0", rvalid); end
      checks++; if (rcount !== 4'd1) begin errors++; $display("FAIL simul_count got %0d want 1", rcount); end
      checks++; if (rdy !== 5'b11111) begin errors++; $display("FAIL simul_tready_back got %b want 11111", rdy); end
   endtask

   task automatic test_staggered_ties;
      int order [5] = '{4, 0, 3, 1, 2};
      logic [4:0] mask;
      int n;
      rready = 1'b1;
      mask   = 5'b00000;
      for (int i = 0; i < 5; i++) begin
         drive(5'b00001 << order[i], 50, 50, 50, 50, 50);
         tick;
         mask = mask | (5'b00001 << order[i]);
         v    = 5'b00000;
         checks++; if (rdy !== ~mask) begin errors++; $display("FAIL stagger_tready step %0d got %b want %b", i, rdy, ~mask); end
      end
      wait_valid(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL stagger_latency got %0d want 4", n); end
      checks++; if (rclass !== 3'd0) begin errors++; $display("FAIL stagger_class got %0d want 0", rclass); end
      checks++; if (rdy !== 5'b00000) begin errors++; $display("FAIL stagger_hold_tready got %b want 00000", rdy); end
      tick;
      checks++; if (rcount !== 4'd2) begin errors++; $display("FAIL stagger_count got %0d want 2", rcount); end
   endtask

   task automatic test_signed;
      int n;
      rready = 1'b1;
      drive(5'b11111, -100, -5, -2048, -6, -5);
      tick;
      v = 5'b00000;
      wait_valid(n);
      checks++; if (rclass !== 3'd1) begin errors++; $display("FAIL signed_class got %0d want 1", rclass); end
      checks++; if (rscore !== exp_score(-5)) begin errors++; $display("FAIL signed_score got %h want %h", rscore, exp_score(-5)); end
      tick;
      checks++; if (rcount !== 4'd3) begin errors++; $display("FAIL signed_count got %0d want 3", rcount); end
   endtask

   task automatic test_back_to_back;
      int n;
      logic [24:0] want;
      rready = 1'b0;
      drive(5'b11111, 1, 2, 3, 4, 5);
      tick;
      v = 5'b00000;
      wait_valid(n);
      checks++; if (rclass !== 3'd4) begin errors++; $display("FAIL bp_class got %0d want 4", rclass); end
      drive(5'b11111, 9, 0, 0, 0, 0);
      want = {1'b1, 3'd4, exp_score(5), 5'b00000, 4'd3};
      for (int i = 0; i < 10; i++) begin
         tick;
         checks++;
         if ({rvalid, rclass, rscore, rdy, rcount} !== want) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got %h want %h", i, {rvalid, rclass, rscore, rdy, rcount}, want);
         end
      end
      rready = 1'b1;
      tick;
      checks++; if (rdy !== 5'b11111) begin errors++; $display("FAIL bp_release_tready got %b want 11111", rdy); end
      checks++; if (rcount !== 4'd4) begin errors++; $display("FAIL bp_release_count got %0d want 4", rcount); end
      tick;
      v = 5'b00000;
      checks++; if (rdy !== 5'b00000) begin errors++; $display("FAIL bp_accept_tready got %b want 00000", rdy); end
      checks++; if (rcount !== 4'd4) begin errors++; $display("FAIL bp_single_increment got %0d want 4", rcount); end
      wait_valid(n);
      checks++; if (rclass !== 3'd0) begin errors++; $display("FAIL bp_next_class got %0d want 0", rclass); end
      checks++; if (rscore !== exp_score(9)) begin errors++; $display("FAIL bp_next_score got %h want %h", rscore, exp_score(9)); end
      tick;
      checks++; if (rcount !== 4'd5) begin errors++; $display("FAIL bp_next_count got %0d want 5", rcount); end
   endtask

   task automatic test_reset_mid;
      int n;
      rready = 1'b1;
      drive(5'b00111, 500, 400, 300, 0, 0);
      tick;
      v = 5'b00000;
      checks++; if (rdy !== 5'b11000) begin errors++; $display("FAIL mid_partial_tready got %b want 11000", rdy); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++; if (rdy !== 5'b11111) begin errors++; $display("FAIL mid_tready got %b want 11111", rdy); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b want 0", rvalid); end
      checks++; if (rcount !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", rcount); end
      drive(5'b11111, 0, 0, 0, 100, -1);
      tick;
      v = 5'b00000;
      wait_valid(n);
      checks++; if (rclass !== 3'd3) begin errors++; $display("FAIL mid_class got %0d want 3", rclass); end
      checks++; if (rscore !== exp_score(100)) begin errors++; $display("FAIL mid_score got %h want %h", rscore, exp_score(100)); end
      tick;
      checks++; if (rcount !== 4'd1) begin errors++; $display("FAIL mid_after_count got %0d want 1", rcount); end
   endtask

   task automatic test_wrap;
      int n;
      int w;
      int s [5];
      rready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         w = i % 5;
         for (int k = 0; k < 5; k++) begin
            s[k] = (k == w) ? 20 : k - 7;
         end
         drive(5'b11111, s[0], s[1], s[2], s[3], s[4]);
         tick;
         v = 5'b00000;
         wait_valid(n);
         checks++; if (rclass !== 3'(w)) begin errors++; $display("FAIL wrap_class iter %0d got %0d want %0d", i, rclass, w); end
         tick;
         checks++; if (rcount !== CW'((2 + i) % 16)) begin errors++; $display("FAIL wrap_count iter %0d got %0d want %0d", i, rcount, (2 + i) % 16); end
      end
   endtask

   initial begin
      test_reset;
      test_simultaneous;
      test_staggered_ties;
      test_signed;
      test_back_to_back;
      test_reset_mid;
      test_wrap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
